// File: rtl/sram_stage_sequencer_pkg.sv
// Shared state type and index sizing helpers for the SRAM stage sequencer.
package sram_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_RUN,
        S_DONE
    } seq_state_t;

    // The stage index must also hold NUM_CLIENTS itself ("past the last stage").
    function automatic int idx_width(input int num_clients);
        return $clog2(num_clients) + 1;
    endfunction

    // Width needed to select one of the real stages (never the past-the-end value).
    function automatic int sel_width(input int num_clients);
        return (num_clients > 1) ? $clog2(num_clients) : 1;
    endfunction

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Stage-side and SRAM-controller-side bus of the stage sequencer.
interface sram_stage_sequencer_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
);
    logic [NUM_CLIENTS*ADDR_W-1:0] client_address_i;
    logic [NUM_CLIENTS*DATA_W-1:0] client_write_data_i;
    logic [NUM_CLIENTS-1:0]        client_we_n_i;
    logic [NUM_CLIENTS-1:0]        client_finish_i;
    logic [NUM_CLIENTS-1:0]        client_start_o;
    logic [ADDR_W-1:0]             idle_address_i;
    logic [ADDR_W-1:0]             SRAM_address_o;
    logic [DATA_W-1:0]             SRAM_write_data_o;
    logic                          SRAM_we_n_o;

    // Sequencer side: starts stages and owns the SRAM controller port.
    modport master (
        input  client_address_i, client_write_data_i, client_we_n_i,
        input  client_finish_i, idle_address_i,
        output client_start_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );

    // Stage / display-reader / SRAM-controller side.
    modport slave (
        output client_address_i, client_write_data_i, client_we_n_i,
        output client_finish_i, idle_address_i,
        input  client_start_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );
endinterface

// File: rtl/sram_stage_sequencer_watchdog.sv
// Per-stage watchdog: counts enabled cycles from a clear, flags the terminal count.
module seq_watchdog #(
    parameter int TIMEOUT_W = 26,
    parameter int TIMEOUT   = 49999999
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [TIMEOUT_W-1:0] count_q;

    // Cycle counter; clear has priority so a new stage always starts from zero.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == TIMEOUT_W'(TIMEOUT - 1));
endmodule

// File: rtl/sram_stage_sequencer.sv
// Runs enabled processing stages in index order and hands the single SRAM port
// to the running stage, returning it to the display reader when idle.
module sram_stage_sequencer
    import sram_seq_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_W   = 26,
    parameter int TIMEOUT     = 49999999
) (
    input  logic                                  CLOCK_50_I,
    input  logic                                  resetn,
    input  logic                                  run_i,
    input  logic                                  abort_i,
    input  logic [NUM_CLIENTS-1:0]                enable_mask_i,
    sram_stage_sequencer_if.master                bus,
    output logic [idx_width(NUM_CLIENTS)-1:0]     active_client_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  timeout_o,
    output logic                                  display_enable_o
);
    localparam int IDX_W = idx_width(NUM_CLIENTS);
    localparam int SEL_W = sel_width(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_CLIENTS);

    seq_state_t             state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [NUM_CLIENTS-1:0] mask_q, mask_d;
    logic [NUM_CLIENTS-1:0] start_q;
    logic                   timeout_d;
    logic                   wd_clear, wd_enable, wd_expired;

    assign sel_q = index_q[SEL_W-1:0];
    assign sel_d = index_d[SEL_W-1:0];

    seq_watchdog #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .expired_o  (wd_expired)
    );

    // Next-state logic: stage walk, finish/timeout handling, abort override.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        mask_d    = mask_q;
        timeout_d = timeout_o;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    mask_d    = enable_mask_i;
                    timeout_d = 1'b0;
                    index_d   = '0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (index_q == END_IDX) begin
                    state_d = S_DONE;
                end else if (!mask_q[sel_q]) begin
                    index_d = index_q + 1'b1;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_clear = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                wd_enable = 1'b1;
                if (bus.client_finish_i[sel_q]) begin
                    index_d = index_q + 1'b1;
                    state_d = S_SELECT;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            timeout_d = timeout_o;
        end
    end

    // State register plus control outputs registered from the next state.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_IDLE;
            index_q          <= '0;
            mask_q           <= '0;
            start_q          <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
            display_enable_o <= 1'b1;
            active_client_o  <= END_IDX;
        end else begin
            state_q          <= state_d;
            index_q          <= index_d;
            mask_q           <= mask_d;
            start_q          <= (state_d == S_START) ? (NUM_CLIENTS'(1) << sel_d) : '0;
            busy_o           <= (state_d != S_IDLE);
            done_o           <= (state_d == S_DONE);
            timeout_o        <= timeout_d;
            display_enable_o <= (state_d == S_IDLE);
            active_client_o  <= (state_d == S_IDLE) ? END_IDX : index_d;
        end
    end

    assign bus.client_start_o = start_q;

    // SRAM port mux: the stage owns the port only while being started or running.
    always_comb begin
        bus.SRAM_address_o    = bus.idle_address_i;
        bus.SRAM_write_data_o = '0;
        bus.SRAM_we_n_o       = 1'b1;
        if ((state_q == S_START) || (state_q == S_RUN)) begin
            bus.SRAM_address_o    = bus.client_address_i[sel_q*ADDR_W +: ADDR_W];
            bus.SRAM_write_data_o = bus.client_write_data_i[sel_q*DATA_W +: DATA_W];
            bus.SRAM_we_n_o       = bus.client_we_n_i[sel_q];
        end
    end
endmodule

// File: doc/sram_stage_sequencer.md
# sram_stage_sequencer

Parametrised SRAM ownership sequencer for the image-decoder top level. It runs up to NUM_CLIENTS processing stages (e.g. IDCT/dequant stage, colourspace/upsampling stage) in fixed index order, issuing a one-cycle start to each enabled stage and waiting for its finish. It multiplexes the active stage's address, data and write-enable onto the single SRAM controller port, and returns ownership to the display reader when idle. Unlike the hard-wired top-level mux, it supports a runtime enable mask, a per-stage watchdog timeout, abort, and a generic client count.

## Interface
- NUM_CLIENTS, 2, number of sequenced stages (1..8)
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- TIMEOUT_W, 26, watchdog counter width
- TIMEOUT, 49999999, cycles a stage may run before abort (1 s at 50 MHz)

- CLOCK_50_I  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- run_i  in  1  pulse: start a sequence (ignored unless idle)
- abort_i  in  1  pulse: abandon current sequence
- enable_mask_i  in  NUM_CLIENTS  bit k=1 runs stage k; sampled when run_i is accepted
- client_address_i  in  NUM_CLIENTS*ADDR_W  stage k address at bits [k*ADDR_W +: ADDR_W]
- client_write_data_i  in  NUM_CLIENTS*DATA_W  stage k write data, same packing
- client_we_n_i  in  NUM_CLIENTS  stage k write enable, active-low
- client_finish_i  in  NUM_CLIENTS  stage k completion (level or pulse)
- client_start_o  out  NUM_CLIENTS  one-cycle start to stage k
- idle_address_i  in  ADDR_W  display reader address, owns SRAM when idle
- SRAM_address_o  out  ADDR_W  to SRAM controller
- SRAM_write_data_o  out  DATA_W  to SRAM controller
- SRAM_we_n_o  out  1  to SRAM controller
- active_client_o  out  $clog2(NUM_CLIENTS)+1  index of owning stage; NUM_CLIENTS when idle
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse: sequence completed normally
- timeout_o  out  1  sticky: last sequence aborted by watchdog
- display_enable_o  out  1  high only in S_IDLE

## Operation
- States: S_IDLE, S_SELECT, S_START, S_RUN, S_DONE.
- S_IDLE: mux selects idle_address_i, we_n=1, data=0. On run_i: latch enable_mask_i, clear timeout_o, stage index=0, go S_SELECT.
- S_SELECT: if index==NUM_CLIENTS go S_DONE; else if mask[index]=0 increment index, stay; else go S_START. Skipping costs one cycle per disabled stage.
- S_START: client_start_o[index]=1 for exactly this cycle; mux already selects stage index; watchdog cleared; go S_RUN.
- S_RUN: mux selects stage index. client_finish_i[index] is sampled only here (finish asserted during S_START is ignored). On finish: index+1, go S_SELECT. Else if watchdog == TIMEOUT-1: set timeout_o, go S_IDLE. Finish and timeout same cycle: finish wins.
- S_DONE: done_o=1 one cycle, go S_IDLE.
- abort_i in any non-idle state: go S_IDLE next cycle, no done_o, timeout_o unchanged; highest priority over finish/timeout.
- run_i while busy: ignored. Mask all zero: run completes via S_DONE with no starts.
- Finish of non-active stages ignored; we_n of non-active stages never reaches SRAM.
- Reset values: state S_IDLE, all client_start_o=0, busy_o=0, done_o=0, timeout_o=0, display_enable_o=1, SRAM_we_n_o=1, active_client_o=NUM_CLIENTS, watchdog=0.

## Timing
- Control outputs (start, done, busy, timeout, display_enable, active_client) are registered.
- SRAM mux outputs are combinational from registered state/index plus client inputs: zero-cycle path client→SRAM.
- run_i at edge n → first enabled stage k start asserted in cycle n+1+(number of disabled stages before k)+1.
- finish at edge m → next start at m+2 (plus skip cycles); done_o at m+2 after last stage.
- Watchdog counts from 0 in first S_RUN cycle; timeout fires in S_RUN cycle TIMEOUT-1 after start.
- SRAM ownership changes only on state transitions; we_n forced 1 in S_IDLE, S_SELECT, S_DONE.

## Structure
- Package sram_seq_pkg: state enum seq_state_t, helper constant for index width.
- Sub-module seq_watchdog: TIMEOUT_W counter with clear, enable, terminal-count output.
- Mux implemented as indexed part-select, no per-client hand-coded branches.

## Test plan
- NUM_CLIENTS=2, mask=2'b11, run_i; stage0 finish after 5 cycles, stage1 after 8 -> start0 then start1 one cycle each, addresses follow active stage, done_o once, display_enable_o returns high.
- mask=2'b10 -> start0 never asserts, start1 asserts two cycles after S_SELECT entry, done_o follows stage1 finish by 2 cycles.
- TIMEOUT=20, stage0 never finishes -> timeout_o=1 at cycle 20 of S_RUN, state idle, no done_o, stage1 never started; next run_i clears timeout_o.
- abort_i during stage1 S_RUN coincident with finish -> idle next cycle, no done_o, SRAM_we_n_o=1.
- finish held high from S_START and run_i repeated while busy -> finish honored only in S_RUN, second run_i ignored.
- resetn asserted mid-stage with client_we_n_i=0 -> SRAM_we_n_o=1, all reset values immediately, asynchronously.
